// File: rtl/prg_ram_writer.sv
// PRG loader: strips the 2-byte load-address header and writes the image into C64 RAM.
// Optional BASIC pointer fix-up after the image is enabled by `define PRG_BASIC_PTR_EN.
module prg_ram_writer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_prg,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [22:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_we,
  input  logic        ram_ack,
  output logic [15:0] prg_start,
  output logic [15:0] prg_end,
  output logic        prg_done,
  output logic        prg_err
);

  // state  | meaning
  // IDLE   | waiting for a PRG download to start
  // HDR    | collecting the two load-address bytes
  // DATA   | waiting for the next image byte or end of download
  // WRITE  | RAM write in flight, loader held off
  // PTR    | issuing BASIC pointer writes (PRG_BASIC_PTR_EN only)
  // FINISH | one-cycle done pulse
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
`ifdef PRG_BASIC_PTR_EN
    PTR,
`endif
    FINISH
  } state_t;

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  state_t        state, state_d;
  logic          dl_q;
  logic [1:0]    hdr_cnt, hdr_cnt_d;
  logic [15:0]   ram_addr_d, prg_start_d, prg_end_d;
  logic [7:0]    ram_data_d;
  logic          prg_err_d;
  logic [TW-1:0] tmo_cnt, tmo_d;
  logic [23:0]   data_addr;
  logic [16:0]   end_sum;
  logic [15:0]   end_sat;
  state_t        write_ret;
  logic          end_update;

`ifdef PRG_BASIC_PTR_EN
  logic [3:0] ptr_idx, ptr_idx_d;
  logic       ptr_act, ptr_act_d;

  function automatic logic [15:0] ptr_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    ptr_addr = 16'h002D;
      3'd1:    ptr_addr = 16'h002E;
      3'd2:    ptr_addr = 16'h002F;
      3'd3:    ptr_addr = 16'h0030;
      3'd4:    ptr_addr = 16'h0031;
      3'd5:    ptr_addr = 16'h0032;
      3'd6:    ptr_addr = 16'h00AE;
      default: ptr_addr = 16'h00AF;
    endcase
  endfunction

  assign write_ret  = ptr_act ? PTR : DATA;
  assign end_update = ~ptr_act;
`else
  assign write_ret  = DATA;
  assign end_update = 1'b1;
`endif

  // 24-bit so any start + offset beyond $FFFF shows up in the upper byte
  assign data_addr = {8'd0, prg_start} + {1'b0, ioctl_addr} - 24'd2;
  assign end_sum   = {1'b0, ram_addr} + 17'd1;
  assign end_sat   = end_sum[16] ? 16'hFFFF : end_sum[15:0];

  // Decoded from state so an async reset drops them without waiting for a clock
  assign ram_we     = (state == WRITE);
  assign ioctl_wait = (state == WRITE);
  assign prg_done   = (state == FINISH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dl_q      <= 1'b0;
      hdr_cnt   <= 2'd0;
      ram_addr  <= 16'd0;
      ram_data  <= 8'd0;
      prg_start <= 16'd0;
      prg_end   <= 16'd0;
      prg_err   <= 1'b0;
      tmo_cnt   <= '0;
`ifdef PRG_BASIC_PTR_EN
      ptr_idx   <= 4'd0;
      ptr_act   <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      dl_q      <= ioctl_download;
      hdr_cnt   <= hdr_cnt_d;
      ram_addr  <= ram_addr_d;
      ram_data  <= ram_data_d;
      prg_start <= prg_start_d;
      prg_end   <= prg_end_d;
      prg_err   <= prg_err_d;
      tmo_cnt   <= tmo_d;
`ifdef PRG_BASIC_PTR_EN
      ptr_idx   <= ptr_idx_d;
      ptr_act   <= ptr_act_d;
`endif
    end
  end

  always_comb begin
    state_d     = state;
    hdr_cnt_d   = hdr_cnt;
    ram_addr_d  = ram_addr;
    ram_data_d  = ram_data;
    prg_start_d = prg_start;
    prg_end_d   = prg_end;
    prg_err_d   = prg_err;
    tmo_d       = tmo_cnt;
`ifdef PRG_BASIC_PTR_EN
    ptr_idx_d   = ptr_idx;
    ptr_act_d   = ptr_act;
`endif
    case (state)
      IDLE: begin
        if (ioctl_download && !dl_q && load_prg) begin
          prg_err_d = 1'b0;
          hdr_cnt_d = 2'd0;
          state_d   = HDR;
        end
      end
      HDR: begin
        if (!ioctl_download) begin
          prg_err_d = 1'b1;
          state_d   = FINISH;
        end else if (ioctl_wr && ioctl_addr == 23'd0) begin
          prg_start_d[7:0] = ioctl_data;
          if (hdr_cnt != 2'd3) hdr_cnt_d = hdr_cnt + 2'd1;
        end else if (ioctl_wr && ioctl_addr == 23'd1) begin
          prg_start_d[15:8] = ioctl_data;
          if (hdr_cnt != 2'd3) hdr_cnt_d = hdr_cnt + 2'd1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (!ioctl_download) begin
          if (hdr_cnt < 2'd2) begin
            prg_err_d = 1'b1;
            state_d   = FINISH;
          end else begin
`ifdef PRG_BASIC_PTR_EN
            ptr_act_d = 1'b1;
            ptr_idx_d = 4'd0;
            state_d   = PTR;
`else
            state_d   = FINISH;
`endif
          end
        end else if (ioctl_wr && ioctl_addr >= 23'd2) begin
          if (data_addr[23:16] != 8'd0) begin
            prg_err_d = 1'b1;
          end else begin
            ram_addr_d = data_addr[15:0];
            ram_data_d = ioctl_data;
            tmo_d      = TW'(ACK_TIMEOUT - 1);
            state_d    = WRITE;
          end
        end
      end
      WRITE: begin
        if (ioctl_wr) prg_err_d = 1'b1;
        if (ram_ack) begin
          tmo_d = '0;
          if (end_update) prg_end_d = end_sat;
          state_d = write_ret;
        end else if (tmo_cnt == '0) begin
          prg_err_d = 1'b1;
          state_d   = write_ret;
        end else begin
          tmo_d = tmo_cnt - TW'(1);
        end
      end
`ifdef PRG_BASIC_PTR_EN
      PTR: begin
        if (ptr_idx == 4'd8) begin
          ptr_act_d = 1'b0;
          state_d   = FINISH;
        end else begin
          ram_addr_d = ptr_addr(ptr_idx[2:0]);
          ram_data_d = ptr_idx[0] ? prg_end[15:8] : prg_end[7:0];
          ptr_idx_d  = ptr_idx + 4'd1;
          tmo_d      = TW'(ACK_TIMEOUT - 1);
          state_d    = WRITE;
        end
      end
`endif
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/prg_ram_writer.md
PRG_RAM_WRITER -- requirements
Module: prg_ram_writer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, max clk cycles a RAM write may wait for ram_ack.
REQ-002 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports load_prg, ioctl_download, ioctl_wr  in  1 each  loader PRG select, download window, one-cycle byte strobe.
REQ-005 SHALL have ports ioctl_addr  in  23 and ioctl_data  in  8  byte offset within image and byte value, both valid while ioctl_wr=1.
REQ-006 SHALL have port ioctl_wait  out  1  backpressure to the loader.
REQ-007 SHALL have ports ram_addr  out  16, ram_data  out  8, ram_we  out  1  C64 RAM write request.
REQ-008 SHALL have port ram_ack  in  1  one-cycle write-complete pulse from the RAM arbiter.
REQ-009 SHALL have ports prg_start, prg_end  out  16 each  load address and end address (last written byte +1).
REQ-010 SHALL have ports prg_done  out  1 (one-cycle pulse) and prg_err  out  1 (sticky error flag).

Function
REQ-011 SHALL use states IDLE, HDR, DATA, WRITE, PTR, FINISH.
REQ-012 IDLE: on ioctl_download=1 with load_prg=1 SHALL clear prg_err and the byte counter and go to HDR; with load_prg=0 the download SHALL be ignored (no ram_we, ioctl_wait=0).
REQ-013 HDR: on ioctl_wr, offset 0 SHALL load prg_start[7:0], offset 1 SHALL load prg_start[15:8] and enter DATA.
REQ-014 DATA: on ioctl_wr with offset N>=2 SHALL latch ram_addr=prg_start+(N-2) and ram_data=ioctl_data, assert ram_we and ioctl_wait the next cycle, and enter WRITE.
REQ-015 WRITE: ram_we and ioctl_wait SHALL stay high until the cycle ram_ack=1; on the next cycle both SHALL drop, and prg_end SHALL become ram_addr+1 (17-bit sum, saturate to 16'hFFFF on carry), then return to DATA.
REQ-016 If prg_start+(N-2) exceeds 16'hFFFF the byte SHALL be dropped (no ram_we) and prg_err set.
REQ-017 An ioctl_wr arriving in WRITE SHALL be discarded and SHALL set prg_err.
REQ-018 If ram_ack is absent for ACK_TIMEOUT cycles after ram_we rises, ram_we SHALL drop, prg_err SHALL set, and the FSM SHALL return to DATA.
REQ-019 On ioctl_download falling: any in-flight WRITE SHALL complete first; if fewer than 2 header bytes were received, prg_err SHALL set and PTR SHALL be skipped; otherwise the FSM SHALL enter PTR (macro on) or FINISH.
REQ-020 FINISH SHALL pulse prg_done for exactly one cycle and return to IDLE.
REQ-021 A new ioctl_download rising edge SHALL be accepted only in IDLE.

Reset
REQ-022 While reset=1: state IDLE; ram_we, ioctl_wait, prg_done, prg_err = 0; ram_addr, ram_data, prg_start, prg_end = 0; timeout counter = 0.
REQ-023 Reset asserted mid-WRITE SHALL drop ram_we immediately (asynchronously), with no further RAM write.

Configuration
REQ-024 Macro PRG_BASIC_PTR_EN SHALL control BASIC pointer fix-up.
REQ-025 Macro defined: PTR SHALL issue 8 sequential writes, each with the WRITE handshake: prg_end low/high bytes to $002D/$002E, $002F/$0030, $0031/$0032, $00AE/$00AF, in that order, then enter FINISH.
REQ-026 Macro undefined: PTR SHALL not exist; download end SHALL go directly to FINISH, and no writes below the PRG image SHALL occur.

Verification
REQ-027 Bytes 01 08 AA BB CC, ram_ack one cycle after each ram_we -> writes $0801=AA, $0802=BB, $0803=CC; prg_start=$0801, prg_end=$0804; one prg_done pulse; prg_err=0.
REQ-028 Same image with PRG_BASIC_PTR_EN -> additional writes $2D=04,$2E=08,$2F=04,$30=08,$31=04,$32=08,$AE=04,$AF=08 after $0803; then prg_done.
REQ-029 Header FF FF, 2 data bytes -> $FFFF written, second byte dropped, prg_err=1, prg_end=$FFFF.
REQ-030 ram_ack held low -> ram_we drops after 255 cycles, prg_err=1, next byte still accepted.
REQ-031 Download with only 1 byte -> no ram_we, prg_err=1, prg_done pulse.
REQ-032 reset pulsed while ram_we=1 -> ram_we=0 in the same cycle, state IDLE, all outputs at reset values.
